pcie_pipe_gearbox_xn: RTL and testbench

Multi-lane, width-parametrised gearbox between per-lane byte-serial link symbols (one byte plus K flag per lane per pcieclk) and PIPE-width parallel words.
It is the xN successor of the x1 PIPE adapter, adding the following on top of the x1 adapter's function:
- a lane count parameter
- an internal word-phase counter in place of a separate pclk
- per-lane RX valid masking
- per-lane TX electrical-idle word aggregation

The block sits between the VHost link ports (LinkIn/LinkOut lanes) and the PIPE-facing PHY/DUT interface. It is fully synchronous to pcieclk.

---
 rtl/pcie_pipe_gearbox_xn.sv | 152 +++++++++++++++
 tb/tb_pcie_pipe_gearbox_xn.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_pipe_gearbox_xn.sv
// Multi-lane gearbox between per-lane byte-serial link symbols and PIPE-width words.
// Optional lane reversal is built when PIPE_GEARBOX_LANE_REVERSAL_EN is defined.
module pcie_pipe_gearbox_xn #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          pcieclk,
    input  logic                          nreset,
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
    input  logic                          lane_rev,
`endif
    output logic                          word_start,
    output logic                          word_end,
    input  logic [LANES*DATA_WIDTH-1:0]   rx_data,
    input  logic [LANES*DATA_WIDTH/8-1:0] rx_datak,
    input  logic [LANES-1:0]              rx_valid,
    output logic [LANES*8-1:0]            link_rx_data,
    output logic [LANES-1:0]              link_rx_k,
    output logic [LANES-1:0]              link_rx_valid,
    input  logic [LANES*8-1:0]            link_tx_data,
    input  logic [LANES-1:0]              link_tx_k,
    input  logic [LANES-1:0]              link_tx_eidle,
    output logic [LANES*DATA_WIDTH-1:0]   tx_data,
    output logic [LANES*DATA_WIDTH/8-1:0] tx_datak,
    output logic [LANES-1:0]              tx_elecidle,
    output logic                          tx_word_valid
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int PW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          rev_cur;

    logic [LANES-1:0][DATA_WIDTH-1:0] rx_sample_q, rx_sample_d;
    logic [LANES-1:0][BPW-1:0]        rx_k_q, rx_k_d;
    logic [LANES-1:0]                 rx_valid_q, rx_valid_d;

    logic [LANES-1:0][DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [LANES-1:0][BPW-1:0]        tx_k_shift_q, tx_k_shift_d;
    logic [LANES-1:0]                 eidle_acc_q, eidle_acc_d;
    logic [LANES-1:0][DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [LANES-1:0][BPW-1:0]        tx_datak_q, tx_datak_d;
    logic [LANES-1:0]                 tx_elecidle_q, tx_elecidle_d;
    logic                             tx_word_valid_q, tx_word_valid_d;

    function automatic int lane_map(input int lane, input logic rev);
        return rev ? (LANES - 1 - lane) : lane;
    endfunction

    assign word_start = (phase_q == '0);
    assign word_end   = (phase_q == PW'(BPW - 1));

    always_comb begin
        phase_d = word_end ? '0 : phase_q + PW'(1);
    end

`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
    // The word loaded at phase 0 already follows the new lane_rev value.
    logic rev_q;
    assign rev_cur = word_start ? lane_rev : rev_q;

    always_ff @(posedge pcieclk or negedge nreset) begin
        if (!nreset) rev_q <= 1'b0;
        else         rev_q <= rev_cur;
    end
`else
    assign rev_cur = 1'b0;
`endif

    // Invalid lanes load zeros, so the whole word is masked.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rx_sample_d[l] = rx_sample_q[l] >> 8;
            rx_k_d[l]      = rx_k_q[l] >> 1;
            rx_valid_d[l]  = rx_valid_q[l];
            if (word_start) begin
                rx_valid_d[l]  = rx_valid[lane_map(l, rev_cur)];
                rx_sample_d[l] = rx_valid_d[l] ?
                    rx_data[lane_map(l, rev_cur)*DATA_WIDTH +: DATA_WIDTH] : '0;
                rx_k_d[l]      = rx_valid_d[l] ?
                    rx_datak[lane_map(l, rev_cur)*BPW +: BPW] : '0;
            end
        end
    end

    always_comb begin
        tx_data_d       = tx_data_q;
        tx_datak_d      = tx_datak_q;
        tx_elecidle_d   = tx_elecidle_q;
        tx_word_valid_d = word_end;
        for (int l = 0; l < LANES; l++) begin
            tx_shift_d[l]   = (tx_shift_q[l] >> 8) |
                              (DATA_WIDTH'(link_tx_data[l*8 +: 8]) << (DATA_WIDTH - 8));
            tx_k_shift_d[l] = (tx_k_shift_q[l] >> 1) |
                              (BPW'(link_tx_k[l]) << (BPW - 1));
            eidle_acc_d[l]  = word_start ? link_tx_eidle[l]
                                         : (eidle_acc_q[l] & link_tx_eidle[l]);
        end
        if (word_end) begin
            for (int p = 0; p < LANES; p++) begin
                tx_data_d[p]     = tx_shift_d[lane_map(p, rev_cur)];
                tx_datak_d[p]    = tx_k_shift_d[lane_map(p, rev_cur)];
                tx_elecidle_d[p] = eidle_acc_d[lane_map(p, rev_cur)];
            end
        end
    end

    always_ff @(posedge pcieclk or negedge nreset) begin
        if (!nreset) begin
            phase_q         <= '0;
            rx_sample_q     <= '0;
            rx_k_q          <= '0;
            rx_valid_q      <= '0;
            tx_shift_q      <= '0;
            tx_k_shift_q    <= '0;
            eidle_acc_q     <= '0;
            tx_data_q       <= '0;
            tx_datak_q      <= '0;
            tx_elecidle_q   <= '1;
            tx_word_valid_q <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            rx_sample_q     <= rx_sample_d;
            rx_k_q          <= rx_k_d;
            rx_valid_q      <= rx_valid_d;
            tx_shift_q      <= tx_shift_d;
            tx_k_shift_q    <= tx_k_shift_d;
            eidle_acc_q     <= eidle_acc_d;
            tx_data_q       <= tx_data_d;
            tx_datak_q      <= tx_datak_d;
            tx_elecidle_q   <= tx_elecidle_d;
            tx_word_valid_q <= tx_word_valid_d;
        end
    end

    always_comb begin
        link_rx_data = '0;
        link_rx_k    = '0;
        for (int l = 0; l < LANES; l++) begin
            link_rx_data[l*8 +: 8] = rx_sample_q[l][7:0];
            link_rx_k[l]           = rx_k_q[l][0];
        end
    end

    assign link_rx_valid = rx_valid_q;
    assign tx_data       = tx_data_q;
    assign tx_datak      = tx_datak_q;
    assign tx_elecidle   = tx_elecidle_q;
    assign tx_word_valid = tx_word_valid_q;

endmodule

// File: tb/tb_pcie_pipe_gearbox_xn.sv
// Scoreboard bench for pcie_pipe_gearbox_xn: a x4/32-bit instance checked against a
// word-level model, plus a x2/8-bit instance where every cycle is a whole word.
module tb_pcie_pipe_gearbox_xn;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int BPW   = DW / 8;
    localparam int KW    = LANES * BPW;

    logic pcieclk = 1'b0;
    logic nreset  = 1'b0;
    always #5 pcieclk = ~pcieclk;

    logic                    word_start, word_end;
    logic [LANES*DW-1:0]     rx_data = '0;
    logic [KW-1:0]           rx_datak = '0;
    logic [LANES-1:0]        rx_valid = '0;
    logic [LANES*8-1:0]      link_rx_data;
    logic [LANES-1:0]        link_rx_k, link_rx_valid;
    logic [LANES*8-1:0]      link_tx_data = '0;
    logic [LANES-1:0]        link_tx_k = '0;
    logic [LANES-1:0]        link_tx_eidle = '0;
    logic [LANES*DW-1:0]     tx_data;
    logic [KW-1:0]           tx_datak;
    logic [LANES-1:0]        tx_elecidle;
    logic                    tx_word_valid;

    logic        word_start_8, word_end_8;
    logic [15:0] rx_data_8 = '0;
    logic [1:0]  rx_datak_8 = '0;
    logic [1:0]  rx_valid_8 = '0;
    logic [15:0] link_rx_data_8;
    logic [1:0]  link_rx_k_8, link_rx_valid_8;
    logic [15:0] tx_data_8;
    logic [1:0]  tx_datak_8, tx_elecidle_8;
    logic        tx_word_valid_8;

`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
    logic lane_rev = 1'b0;
    logic s_rev = 1'b0;
    logic rand_rev_en = 1'b0;
`endif

    pcie_pipe_gearbox_xn #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
        .pcieclk(pcieclk), .nreset(nreset),
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
        .lane_rev(lane_rev),
`endif
        .word_start(word_start), .word_end(word_end),
        .rx_data(rx_data), .rx_datak(rx_datak), .rx_valid(rx_valid),
        .link_rx_data(link_rx_data), .link_rx_k(link_rx_k), .link_rx_valid(link_rx_valid),
        .link_tx_data(link_tx_data), .link_tx_k(link_tx_k), .link_tx_eidle(link_tx_eidle),
        .tx_data(tx_data), .tx_datak(tx_datak), .tx_elecidle(tx_elecidle),
        .tx_word_valid(tx_word_valid)
    );

    pcie_pipe_gearbox_xn #(.LANES(2), .DATA_WIDTH(8)) dut8 (
        .pcieclk(pcieclk), .nreset(nreset),
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
        .lane_rev(1'b0),
`endif
        .word_start(word_start_8), .word_end(word_end_8),
        .rx_data(rx_data_8), .rx_datak(rx_datak_8), .rx_valid(rx_valid_8),
        .link_rx_data(link_rx_data_8), .link_rx_k(link_rx_k_8), .link_rx_valid(link_rx_valid_8),
        .link_tx_data(link_tx_data[15:0]), .link_tx_k(link_tx_k[1:0]),
        .link_tx_eidle(link_tx_eidle[1:0]),
        .tx_data(tx_data_8), .tx_datak(tx_datak_8), .tx_elecidle(tx_elecidle_8),
        .tx_word_valid(tx_word_valid_8)
    );

    typedef struct {
        logic [LANES*8-1:0] data;
        logic [LANES-1:0]   k;
        logic [LANES-1:0]   v;
    } rx_exp_t;

    typedef struct {
        logic [LANES*DW-1:0] data;
        logic [KW-1:0]       k;
        logic [LANES-1:0]    ei;
    } tx_exp_t;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];

    int   checks = 0;
    int   failures = 0;
    int   phase = 0;
    logic word_rev = 1'b0;
    logic stop = 1'b0;

    logic [7:0] tx_bytes [LANES][BPW];
    logic       tx_kbits [LANES][BPW];
    int         ei_cnt   [LANES];

    logic [LANES*DW-1:0]  s_rxd;
    logic [KW-1:0]        s_rxk;
    logic [LANES-1:0]     s_rxv;
    logic [LANES*8-1:0]   s_txd;
    logic [LANES-1:0]     s_txk, s_txe;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < LANES * DW / 32; i++) s_rxd[i*32 +: 32] = $urandom();
        s_rxk = KW'($urandom());
        s_rxv = LANES'($urandom()) | LANES'($urandom());
        s_txd = (LANES*8)'($urandom());
        s_txk = LANES'($urandom());
        s_txe = LANES'($urandom()) | LANES'($urandom());
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
        s_rev = rand_rev_en ? 1'($urandom_range(0, 1)) : 1'b0;
`endif
    endtask

    // Drives one symbol cycle and records what the link/PIPE sides must show for it.
    task automatic applyStimulus();
        rx_exp_t re;
        tx_exp_t te;
        int src;
        @(negedge pcieclk);
        checkOutput("word_start", word_start, phase == 0);
        checkOutput("word_end", word_end, phase == BPW - 1);
        rx_data = s_rxd; rx_datak = s_rxk; rx_valid = s_rxv;
        link_tx_data = s_txd; link_tx_k = s_txk; link_tx_eidle = s_txe;
        rx_data_8 = 16'($urandom()); rx_datak_8 = 2'($urandom()); rx_valid_8 = 2'($urandom());
        if (phase == 0) begin
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
            word_rev = s_rev;
`else
            word_rev = 1'b0;
`endif
            for (int n = 0; n < BPW; n++) begin
                for (int l = 0; l < LANES; l++) begin
                    src = word_rev ? LANES - 1 - l : l;
                    re.v[l] = s_rxv[src];
                    re.data[l*8 +: 8] = s_rxv[src] ? s_rxd[src*DW + 8*n +: 8] : 8'h00;
                    re.k[l] = s_rxv[src] ? s_rxk[src*BPW + n] : 1'b0;
                end
                rx_q.push_back(re);
            end
        end
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
        lane_rev = s_rev;
`endif
        for (int l = 0; l < LANES; l++) begin
            tx_bytes[l][phase] = s_txd[l*8 +: 8];
            tx_kbits[l][phase] = s_txk[l];
            ei_cnt[l] = (phase == 0 ? 0 : ei_cnt[l]) + (s_txe[l] ? 1 : 0);
        end
        if (phase == BPW - 1) begin
            for (int p = 0; p < LANES; p++) begin
                src = word_rev ? LANES - 1 - p : p;
                for (int n = 0; n < BPW; n++) begin
                    te.data[p*DW + 8*n +: 8] = tx_bytes[src][n];
                    te.k[p*BPW + n] = tx_kbits[src][n];
                end
                te.ei[p] = (ei_cnt[src] == BPW);
            end
            tx_q.push_back(te);
        end
        phase = (phase + 1) % BPW;
    endtask

    task automatic apply_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            randomize_stim();
            applyStimulus();
        end
    endtask

    task automatic align_word();
        while (phase != 0) apply_random(1);
    endtask

    task automatic check_reset();
        checkOutput("rst_tx_elecidle", tx_elecidle, 4'hF);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_tx_datak", tx_datak, 0);
        checkOutput("rst_tx_word_valid", tx_word_valid, 0);
        checkOutput("rst_link_rx_valid", link_rx_valid, 0);
        checkOutput("rst_link_rx_data", link_rx_data, 0);
    endtask

    task automatic reset_dut();
        @(negedge pcieclk);
        nreset = 1'b0;
        rx_q.delete();
        tx_q.delete();
        repeat (2) begin
            @(negedge pcieclk);
            check_reset();
        end
        @(posedge pcieclk);
        #2 nreset = 1'b1;
        phase = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a word.
    initial begin
        logic [LANES*DW-1:0] last_data = '0;
        logic [KW-1:0]       last_k = '0;
        logic [LANES-1:0]    last_ei = '1;
        rx_exp_t re;
        tx_exp_t te;
        forever begin
            @(posedge pcieclk);
            #1;
            if (stop) break;
            if (!nreset) begin
                last_data = '0; last_k = '0; last_ei = '1;
            end else begin
                if (rx_q.size() > 0) begin
                    re = rx_q.pop_front();
                    checkOutput("link_rx_data", link_rx_data, re.data);
                    checkOutput("link_rx_k", link_rx_k, re.k);
                    checkOutput("link_rx_valid", link_rx_valid, re.v);
                end
                if (tx_word_valid) begin
                    if (tx_q.size() == 0) begin
                        checkOutput("tx_unexpected_pulse", tx_word_valid, 0);
                    end else begin
                        te = tx_q.pop_front();
                        checkOutput("tx_data", tx_data, te.data);
                        checkOutput("tx_datak", tx_datak, te.k);
                        checkOutput("tx_elecidle", tx_elecidle, te.ei);
                        last_data = te.data; last_k = te.k; last_ei = te.ei;
                    end
                end else begin
                    checkOutput("tx_data_hold", tx_data, last_data);
                    checkOutput("tx_datak_hold", tx_datak, last_k);
                    checkOutput("tx_elecidle_hold", tx_elecidle, last_ei);
                end
                checkOutput("w8_word_valid", tx_word_valid_8, 1);
                checkOutput("w8_start_end", {word_start_8, word_end_8}, 2'b11);
                checkOutput("w8_tx_data", tx_data_8, link_tx_data[15:0]);
                checkOutput("w8_tx_datak", tx_datak_8, link_tx_k[1:0]);
                checkOutput("w8_tx_elecidle", tx_elecidle_8, link_tx_eidle[1:0]);
                checkOutput("w8_rx_data", link_rx_data_8,
                    {rx_valid_8[1] ? rx_data_8[15:8] : 8'h00, rx_valid_8[0] ? rx_data_8[7:0] : 8'h00});
                checkOutput("w8_rx_k", link_rx_k_8, rx_datak_8 & rx_valid_8);
                checkOutput("w8_rx_valid", link_rx_valid_8, rx_valid_8);
            end
        end
    end

    initial begin
        logic [7:0] t2_bytes [4];
        logic       t2_k [4];
        t2_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        t2_k = '{1'b1, 1'b0, 1'b0, 1'b0};

        $display("[TB] reset hold");
        repeat (3) @(negedge pcieclk);
        check_reset();
        @(posedge pcieclk);
        #2 nreset = 1'b1;
        phase = 0;

        $display("[TB] rx lane 0 serialisation");
        randomize_stim();
        s_rxd[31:0] = 32'h44332211; s_rxk[3:0] = 4'b0001; s_rxv = 4'hF;
        applyStimulus();
        for (int n = 0; n < BPW; n++) begin
            @(posedge pcieclk);
            #2;
            checkOutput("t2_rx_byte", {link_rx_k[0], link_rx_data[7:0]}, {t2_k[n], t2_bytes[n]});
            apply_random(1);
        end

        $display("[TB] tx lane 2 ordered set");
        align_word();
        for (int n = 0; n < BPW; n++) begin
            randomize_stim();
            s_txd[23:16] = (n == 0) ? 8'hBC : 8'h1C;
            s_txk[2] = 1'b1;
            applyStimulus();
        end
        @(posedge pcieclk);
        #2;
        checkOutput("t3_tx_data", tx_data[95:64], 32'h1C1C1CBC);
        checkOutput("t3_tx_datak", tx_datak[11:8], 4'hF);
        checkOutput("t3_tx_word_valid", tx_word_valid, 1);

        $display("[TB] rx lane 1 invalid");
        align_word();
        randomize_stim();
        s_rxd[63:32] = 32'hFFFFFFFF; s_rxv[1] = 1'b0;
        applyStimulus();
        for (int n = 0; n < BPW; n++) begin
            @(posedge pcieclk);
            #2;
            checkOutput("t4_rx_masked", {link_rx_valid[1], link_rx_k[1], link_rx_data[15:8]}, 0);
            apply_random(1);
        end

        $display("[TB] tx lane 3 electrical idle");
        align_word();
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < BPW; n++) begin
                randomize_stim();
                s_txe[3] = (w == 1) || (n != BPW - 1);
                applyStimulus();
            end
            @(posedge pcieclk);
            #2;
            checkOutput("t5_tx_elecidle3", tx_elecidle[3], (w == 1));
        end

`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
        $display("[TB] lane reversal");
        align_word();
        randomize_stim();
        s_rev = 1'b1; s_rxd[31:0] = 32'hCAFEF00D; s_rxv = 4'hF;
        applyStimulus();
        @(posedge pcieclk);
        #2;
        checkOutput("t6_rev_lane3", link_rx_data[31:24], 8'h0D);
        rand_rev_en = 1'b1;
`endif

        $display("[TB] random traffic");
        apply_random(200 * BPW);

        $display("[TB] reset mid-word");
        align_word();
        apply_random(2);
        reset_dut();
`ifdef PIPE_GEARBOX_LANE_REVERSAL_EN
        rand_rev_en = 1'b0;
`endif
        for (int n = 0; n < BPW; n++) begin
            randomize_stim();
            s_txd[7:0] = 8'hA1 + 8'(n * 8'h11);
            applyStimulus();
        end
        @(posedge pcieclk);
        #2;
        checkOutput("t6_first_word", tx_data[31:0], 32'hD4C3B2A1);
        checkOutput("t6_first_pulse", tx_word_valid, 1);

        apply_random(3 * BPW);
        align_word();
        @(posedge pcieclk);
        #3 stop = 1'b1;
        checkOutput("rx_q_drained", rx_q.size(), 0);
        checkOutput("tx_q_drained", tx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
